// File: rtl/split_n.sv
// split_n: broadcast one valid/ready stream to NUM_OUT independent branches.
// BUFFER_DEPTH=0 gives an eager fork; otherwise each branch owns a small FIFO.
module split_n #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_OUT      = 2,
   parameter int BUFFER_DEPTH = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic [NUM_OUT*DATA_WIDTH-1:0] data_out,
   output logic [NUM_OUT-1:0]            data_out_valid,
   input  logic [NUM_OUT-1:0]            data_out_ready
);

   generate
      if (BUFFER_DEPTH == 0) begin : g_eager
         logic [NUM_OUT-1:0] taken;
         logic               xfer;

         always_comb begin
            data_in_ready  = rst_n & (&(taken | data_out_ready));
            data_out_valid = (rst_n && data_in_valid) ? ~taken : '0;
            data_out       = {NUM_OUT{data_in}};
         end

         assign xfer = data_in_valid & data_in_ready;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               taken <= '0;
            end else if (xfer) begin
               taken <= '0;
            end else begin
               taken <= taken | (data_out_valid & data_out_ready);
            end
         end
      end else begin : g_buf
         localparam int CW = $clog2(BUFFER_DEPTH + 1);
         localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
         localparam logic [CW-1:0] FULL = CW'(BUFFER_DEPTH);
         localparam logic [PW-1:0] LAST = PW'(BUFFER_DEPTH - 1);

         logic               rdy_q;
         logic               wr;
         logic [NUM_OUT-1:0] rd;
         logic [NUM_OUT-1:0] nfull;

         // ready is registered, so writes never check fullness again
         assign wr            = data_in_valid & rdy_q;
         assign data_in_ready = rdy_q;

         for (genvar i = 0; i < NUM_OUT; i++) begin : g_br
            logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
            logic [PW-1:0]         wp;
            logic [PW-1:0]         rp;
            logic [CW-1:0]         cnt;
            logic [CW-1:0]         cnt_nxt;

            assign data_out_valid[i] = (cnt != '0);
            assign rd[i]    = data_out_valid[i] & data_out_ready[i];
            assign nfull[i] = (cnt_nxt != FULL);
            assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[rp];

            always_comb begin
               unique case ({wr, rd[i]})
                  2'b10:   cnt_nxt = cnt + 1'b1;
                  2'b01:   cnt_nxt = cnt - 1'b1;
                  default: cnt_nxt = cnt;
               endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  wp  <= '0;
                  rp  <= '0;
                  cnt <= '0;
               end else begin
                  cnt <= cnt_nxt;
                  if (wr) begin
                     wp <= (wp == LAST) ? '0 : wp + 1'b1;
                  end
                  if (rd[i]) begin
                     rp <= (rp == LAST) ? '0 : rp + 1'b1;
                  end
               end
            end

            always_ff @(posedge clk) begin
               if (wr) begin
                  mem[wp] <= data_in;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdy_q <= 1'b0;
            end else begin
               rdy_q <= &nfull;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_split_n.sv
// Scoreboard bench for split_n: one eager 3-way instance and three
// buffered 2-way instances (depths 4, 3 and 1) share clock and reset.
module tb_split_n;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit done = 1'b0;

   logic [7:0] din  [4];
   logic       vin  [4];
   logic [2:0] rout [4];
   wire        rin  [4];
   wire [23:0] dout [4];
   wire [2:0]  vout [4];
   wire [15:0] dob  [1:3];
   wire [1:0]  vob  [1:3];

   logic [7:0] q [4][3][$];

   split_n #(.DATA_WIDTH(8), .NUM_OUT(3), .BUFFER_DEPTH(0)) u_e3 (
      .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_in_valid(vin[0]),
      .data_in_ready(rin[0]), .data_out(dout[0]),
      .data_out_valid(vout[0]), .data_out_ready(rout[0])
   );

   split_n #(.DATA_WIDTH(8), .NUM_OUT(2), .BUFFER_DEPTH(4)) u_b4 (
      .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_in_valid(vin[1]),
      .data_in_ready(rin[1]), .data_out(dob[1]),
      .data_out_valid(vob[1]), .data_out_ready(rout[1][1:0])
   );

   split_n #(.DATA_WIDTH(8), .NUM_OUT(2), .BUFFER_DEPTH(3)) u_b3 (
      .clk(clk), .rst_n(rst_n), .data_in(din[2]), .data_in_valid(vin[2]),
      .data_in_ready(rin[2]), .data_out(dob[2]),
      .data_out_valid(vob[2]), .data_out_ready(rout[2][1:0])
   );

   split_n #(.DATA_WIDTH(8), .NUM_OUT(2), .BUFFER_DEPTH(1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .data_in(din[3]), .data_in_valid(vin[3]),
      .data_in_ready(rin[3]), .data_out(dob[3]),
      .data_out_valid(vob[3]), .data_out_ready(rout[3][1:0])
   );

   assign dout[1] = {8'h00, dob[1]};
   assign dout[2] = {8'h00, dob[2]};
   assign dout[3] = {8'h00, dob[3]};
   assign vout[1] = {1'b0, vob[1]};
   assign vout[2] = {1'b0, vob[2]};
   assign vout[3] = {1'b0, vob[3]};

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int k, logic [7:0] d);
      for (int b = 0; b < ((k == 0) ? 3 : 2); b++) q[k][b].push_back(d);
   endtask

   // called aligned just after a rising edge; returns aligned the same way
   task automatic send_beat(int k, logic [7:0] d);
      bit ok;
      ok = 1'b0;
      din[k] = d;
      vin[k] = 1'b1;
      push(k, d);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = rin[k];
         tick();
      end
      vin[k] = 1'b0;
      if (!ok) chk($sformatf("timeout%0d", k), 32'd0, 32'd1);
   endtask

   // every branch transfer is checked against the head of its queue
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < ((k == 0) ? 3 : 2); b++) begin
               if (vout[k][b] && rout[k][b]) begin
                  if (q[k][b].size() == 0)
                     chk($sformatf("spur%0d_%0d", k, b), 32'(vout[k][b]), 32'd0);
                  else
                     chk($sformatf("data%0d_%0d", k, b),
                         32'(dout[k][b*8 +: 8]), 32'(q[k][b].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      bit acc;
      int j;
      for (int k = 0; k < 4; k++) begin
         din[k]  = 8'h00;
         vin[k]  = 1'b0;
         rout[k] = 3'b000;
      end

      // reset: eager outputs gated even with valid input
      vin[0] = 1'b1;
      din[0] = 8'h99;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_e_vld", 32'(vout[0]), 32'd0);
      chk("rst_e_rdy", 32'(rin[0]), 32'd0);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("rst_b%0d_rdy", k), 32'(rin[k]), 32'd0);
         chk($sformatf("rst_b%0d_vld", k), 32'(vout[k]), 32'd0);
      end
      vin[0] = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 1; k < 4; k++)
         chk($sformatf("post_b%0d_rdy", k), 32'(rin[k]), 32'd1);
      tick();

      // eager back-to-back with all readys high
      rout[0] = 3'b111;
      for (int i = 0; i < 3; i++) begin
         din[0] = 8'(8'h11 * (i + 1));
         vin[0] = 1'b1;
         push(0, din[0]);
         @(negedge clk);
         chk("e_b2b_rdy", 32'(rin[0]), 32'd1);
         chk("e_b2b_vld", 32'(vout[0]), 32'h7);
         tick();
      end
      vin[0] = 1'b0;
      tick();

      // eager staggered acceptance
      din[0] = 8'hA5;
      vin[0] = 1'b1;
      push(0, 8'hA5);
      rout[0] = 3'b001;
      @(negedge clk);
      chk("e_stg0_vld", 32'(vout[0]), 32'h7);
      chk("e_stg0_rdy", 32'(rin[0]), 32'd0);
      tick();
      rout[0] = 3'b010;
      @(negedge clk);
      chk("e_stg1_vld", 32'(vout[0]), 32'h6);
      chk("e_stg1_rdy", 32'(rin[0]), 32'd0);
      tick();
      rout[0] = 3'b100;
      @(negedge clk);
      chk("e_stg2_vld", 32'(vout[0]), 32'h4);
      chk("e_stg2_rdy", 32'(rin[0]), 32'd1);
      tick();
      din[0] = 8'h5A;
      push(0, 8'h5A);
      rout[0] = 3'b111;
      @(negedge clk);
      chk("e_clr_vld", 32'(vout[0]), 32'h7);
      chk("e_clr_rdy", 32'(rin[0]), 32'd1);
      tick();
      vin[0] = 1'b0;

      // depth 4, branch 1 stalled until the fifo fills
      rout[1] = 3'b001;
      for (int i = 0; i < 4; i++) send_beat(1, 8'(i));
      fork
         send_beat(1, 8'd4);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("b4_full_rdy", 32'(rin[1]), 32'd0);
            end
            rout[1] = 3'b011;
         end
      join
      send_beat(1, 8'd5);
      repeat (8) tick();

      // depth 3, random readys across pointer wrap
      fork
         begin
            for (int i = 0; i < 10; i++) send_beat(2, 8'(i));
            done = 1'b1;
         end
         begin
            while (!done) begin
               rout[2] = {1'b0, 2'($urandom)};
               tick();
            end
         end
      join
      rout[2] = 3'b011;
      repeat (8) tick();
      chk("b3_q0", 32'(q[2][0].size()), 32'd0);
      chk("b3_q1", 32'(q[2][1].size()), 32'd0);

      // depth 1: one beat every two cycles
      rout[3] = 3'b011;
      j = 0;
      din[3] = 8'h40;
      vin[3] = 1'b1;
      push(3, 8'h40);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("b1_rdy", 32'(rin[3]), 32'(c % 2 == 0));
         chk("b1_vld", 32'(vout[3]), (c % 2 == 1) ? 32'h3 : 32'h0);
         acc = rin[3];
         tick();
         if (acc) begin
            if (c < 6) begin
               j++;
               din[3] = 8'(8'h40 + j);
               push(3, din[3]);
            end else begin
               vin[3] = 1'b0;
            end
         end
      end

      // reset mid-stream with branch counts 2 and 1
      rout[1] = 3'b000;
      send_beat(1, 8'h61);
      send_beat(1, 8'h62);
      rout[1] = 3'b010;
      tick();
      rout[1] = 3'b000;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("mrst%0d_vld", k), 32'(vout[k]), 32'd0);
         chk($sformatf("mrst%0d_rdy", k), 32'(rin[k]), 32'd0);
         for (int b = 0; b < 3; b++) q[k][b].delete();
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      rout[1] = 3'b011;
      tick();
      chk("mrst_post_rdy", 32'(rin[1]), 32'd1);
      chk("mrst_post_vld", 32'(vout[1]), 32'd0);
      send_beat(1, 8'h7E);
      chk("mrst_lat_vld", 32'(vout[1]), 32'h3);
      repeat (4) tick();

      for (int k = 0; k < 4; k++)
         for (int b = 0; b < ((k == 0) ? 3 : 2); b++)
            chk($sformatf("drain%0d_%0d", k, b), 32'(q[k][b].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
